// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//
// Moore control unit for the single-bus datapath. It walks the datapath
// through fetch (T0..T2) and execute (T3..T6) for register-format ALU
// instructions, MUL/DIV (result to HI/LO), NOP and HALT. The instruction is
// read back from the IR after it has been loaded; the fetch stalls in T1
// until memory signals mem_ready.
//
// Build option:
//   SEQ_SINGLE_STEP_EN - adds input 'step' and a WAIT state entered at every
//                        instruction end; WAIT releases to T0 when step=1,
//                        or drops to IDLE when run=0.
//
// Ports:
//   clock          in   system clock, rising edge
//   clear          in   synchronous active-high reset
//   run            in   start / continue level (sampled in IDLE, T5, T6, WAIT)
//   mem_ready      in   Mdatain valid this cycle (ends the T1 stall)
//   ir_in[31:0]    in   current IR contents
//   step           in   single-step release (SEQ_SINGLE_STEP_EN only)
//   e_PC..e_GP     out  datapath register load enables
//   incPC          out  ALU increment select for the PC
//   MDR_read       out  MDR loads from Mdatain instead of the bus
//   GP_addr[3:0]   out  GP register write select
//   ALU_op[3:0]    out  ALU operation
//   BusDataSelect  out  bus source select (R0-R15, HI, LO, Zhigh, Zlow, PC, MDR)
//   busy           out  high outside IDLE and HALT
//   halted         out  high in HALT
//   illegal        out  sticky undefined-opcode flag
//   state_o[3:0]   out  current FSM state for observation
//
// Handshake: memory read data is accepted on every rising edge in T1 where
// mem_ready=1; there is no backpressure toward memory, the sequencer simply
// holds T1 (with MDR_read/e_MDR asserted) until that edge.
// ---------------------------------------------------------------------------
module instr_sequencer #(
    parameter logic [3:0] INC_OP   = 4'b1111,
    parameter logic [4:0] MUL_OPC  = 5'b01100,
    parameter logic [4:0] DIV_OPC  = 5'b01101,
    parameter logic [4:0] NOP_OPC  = 5'b11011,
    parameter logic [4:0] HALT_OPC = 5'b11100
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        run,
    input  logic        mem_ready,
    input  logic [31:0] ir_in,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic        step,
`endif
    output logic        e_PC,
    output logic        e_IR,
    output logic        e_Y,
    output logic        e_Z,
    output logic        e_HI,
    output logic        e_LO,
    output logic        e_MDR,
    output logic        e_MAR,
    output logic        e_GP,
    output logic        incPC,
    output logic        MDR_read,
    output logic [3:0]  GP_addr,
    output logic [3:0]  ALU_op,
    output logic [4:0]  BusDataSelect,
    output logic        busy,
    output logic        halted,
    output logic        illegal,
    output logic [3:0]  state_o
);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_T0   = 4'd1;
    localparam logic [3:0] S_T1   = 4'd2;
    localparam logic [3:0] S_T2   = 4'd3;
    localparam logic [3:0] S_T3   = 4'd4;
    localparam logic [3:0] S_T4   = 4'd5;
    localparam logic [3:0] S_T5   = 4'd6;
    localparam logic [3:0] S_T6   = 4'd7;
    localparam logic [3:0] S_HALT = 4'd8;
`ifdef SEQ_SINGLE_STEP_EN
    localparam logic [3:0] S_WAIT = 4'd9;
    // Every instruction end parks in WAIT until released by step.
    localparam logic [3:0] S_END  = S_WAIT;
`else
    localparam logic [3:0] S_END  = S_T0;
`endif

    localparam logic [4:0] BDS_HI  = 5'b10000;
    localparam logic [4:0] BDS_ZHI = 5'b10010;
    localparam logic [4:0] BDS_ZLO = 5'b10011;
    localparam logic [4:0] BDS_PC  = 5'b10100;
    localparam logic [4:0] BDS_MDR = 5'b10101;

    logic [3:0] state_q, state_d;
    logic       illegal_q, illegal_d;
    // High only in the first T1 cycle, so the PC loads once per fetch no
    // matter how long memory stalls.
    logic       first_q;

    // IR fields
    logic [4:0] opc;
    logic [3:0] ra, rb, rc;
    logic       unused_ir;

    assign opc       = ir_in[31:27];
    assign ra        = ir_in[26:23];
    assign rb        = ir_in[22:19];
    assign rc        = ir_in[18:15];
    assign unused_ir = ^ir_in[14:0];

    logic is_nop, is_halt, is_mul, is_div, is_alu, is_exec;
    logic [3:0] exec_alu_op;

    assign is_nop  = (opc == NOP_OPC);
    assign is_halt = (opc == HALT_OPC);
    assign is_mul  = (opc == MUL_OPC);
    assign is_div  = (opc == DIV_OPC);
    assign is_alu  = (opc <= 5'b01011);
    assign is_exec = is_alu || is_mul || is_div;

    always_comb begin
        if (is_mul) begin
            exec_alu_op = 4'b1100;
        end else if (is_div) begin
            exec_alu_op = 4'b1101;
        end else begin
            exec_alu_op = opc[3:0];
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE: if (run) state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   if (mem_ready) state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_T3: begin
                if (is_nop) begin
                    state_d = S_END;
                end else if (is_halt) begin
                    state_d = S_HALT;
                end else if (is_exec) begin
                    state_d = S_T4;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_T4:   state_d = S_T5;
            S_T5: begin
                if (is_mul || is_div) begin
                    state_d = S_T6;
                end else begin
                    state_d = run ? S_END : S_IDLE;
                end
            end
            S_T6:   state_d = run ? S_END : S_IDLE;
            S_HALT: state_d = S_HALT;
`ifdef SEQ_SINGLE_STEP_EN
            S_WAIT: begin
                if (!run) begin
                    state_d = S_IDLE;
                end else if (step) begin
                    state_d = S_T0;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
            first_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            first_q   <= (state_q == S_T0);
        end
    end

    // Output decode (from state; execute-phase fields come from the IR)
    always_comb begin
        e_PC          = 1'b0;
        e_IR          = 1'b0;
        e_Y           = 1'b0;
        e_Z           = 1'b0;
        e_HI          = 1'b0;
        e_LO          = 1'b0;
        e_MDR         = 1'b0;
        e_MAR         = 1'b0;
        e_GP          = 1'b0;
        incPC         = 1'b0;
        MDR_read      = 1'b0;
        GP_addr       = 4'd0;
        ALU_op        = 4'd0;
        BusDataSelect = 5'd0;
        case (state_q)
            S_T0: begin
                BusDataSelect = BDS_PC;
                e_MAR         = 1'b1;
                incPC         = 1'b1;
                e_Z           = 1'b1;
                ALU_op        = INC_OP;
            end
            S_T1: begin
                BusDataSelect = BDS_ZLO;
                e_PC          = first_q;
                MDR_read      = 1'b1;
                e_MDR         = 1'b1;
            end
            S_T2: begin
                BusDataSelect = BDS_MDR;
                e_IR          = 1'b1;
            end
            S_T3: begin
                // NOP, HALT and illegal opcodes drive nothing here.
                if (!is_nop && !is_halt && is_exec) begin
                    BusDataSelect = {1'b0, rb};
                    e_Y           = 1'b1;
                end
            end
            S_T4: begin
                BusDataSelect = {1'b0, rc};
                ALU_op        = exec_alu_op;
                e_Z           = 1'b1;
            end
            S_T5: begin
                BusDataSelect = BDS_ZLO;
                if (is_mul || is_div) begin
                    e_LO = 1'b1;
                end else begin
                    GP_addr = ra;
                    e_GP    = 1'b1;
                end
            end
            S_T6: begin
                BusDataSelect = BDS_ZHI;
                e_HI          = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy    = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted  = (state_q == S_HALT);
    assign illegal = illegal_q;
    assign state_o = state_q;

    // HI is never a bus source in this instruction set's sequences.
    logic [4:0] unused_bds_hi;
    assign unused_bds_hi = BDS_HI;

endmodule
